// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for a 5-stage pipeline without forwarding
module pipeline_hazard_ctrl #(
   parameter int RA_W  = 5,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [RA_W-1:0]  id_rs1,
   input  logic             id_rs1_used,
   input  logic [RA_W-1:0]  id_rs2,
   input  logic             id_rs2_used,
   input  logic [RA_W-1:0]  id_rd,
   input  logic             id_regwrite,
   input  logic             pcsrc_mem,
   output logic             en_pc,
   output logic             en_ifid,
   output logic             bubble_idex,
   output logic             flush_ifid,
   output logic             flush_exmem,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [RA_W-1:0]  ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d;
   logic             ex_wr_q, ex_wr_d, mem_wr_q, mem_wr_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   logic             rs1_hit, rs2_hit, hazard;

   // WB producers are never checked: the register file writes on the falling edge.
   always_comb begin
      rs1_hit = id_rs1_used && (id_rs1 != '0) &&
                (((id_rs1 == ex_rd_q) && ex_wr_q) || ((id_rs1 == mem_rd_q) && mem_wr_q));
      rs2_hit = id_rs2_used && (id_rs2 != '0) &&
                (((id_rs2 == ex_rd_q) && ex_wr_q) || ((id_rs2 == mem_rd_q) && mem_wr_q));
      hazard  = id_valid && (state_q != ST_FLUSH) && (rs1_hit || rs2_hit);
   end

   always_comb begin
      state_d     = state_q;
      ex_rd_d     = id_rd;
      ex_wr_d     = id_regwrite && (id_rd != '0);
      mem_rd_d    = ex_rd_q;
      mem_wr_d    = ex_wr_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      en_pc       = 1'b1;
      en_ifid     = 1'b1;
      bubble_idex = 1'b0;
      flush_ifid  = 1'b0;
      flush_exmem = 1'b0;

      if (pcsrc_mem || hazard || !id_valid || (state_q == ST_FLUSH)) begin
         ex_rd_d = '0;
         ex_wr_d = 1'b0;
      end
      if (pcsrc_mem) begin
         mem_rd_d = '0;
         mem_wr_d = 1'b0;
      end

      if (pcsrc_mem) begin
         bubble_idex = 1'b1;
         flush_ifid  = 1'b1;
         flush_exmem = 1'b1;
         if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_ONE;
      end else if (hazard) begin
         en_pc       = 1'b0;
         en_ifid     = 1'b0;
         bubble_idex = 1'b1;
         if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_ONE;
      end

      case (state_q)
         ST_RUN, ST_STALL: begin
            if (pcsrc_mem)   state_d = ST_FLUSH;
            else if (hazard) state_d = ST_STALL;
            else             state_d = ST_RUN;
         end
         ST_FLUSH: state_d = pcsrc_mem ? ST_FLUSH : ST_RUN;
         default:  state_d = ST_RUN;
      endcase

      // Reset holds the front end frozen and the downstream registers empty.
      if (!rst) begin
         en_pc       = 1'b0;
         en_ifid     = 1'b0;
         bubble_idex = 1'b1;
         flush_ifid  = 1'b1;
         flush_exmem = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_RUN;
         ex_rd_q     <= '0;
         ex_wr_q     <= 1'b0;
         mem_rd_q    <= '0;
         mem_wr_q    <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         ex_rd_q     <= ex_rd_d;
         ex_wr_q     <= ex_wr_d;
         mem_rd_q    <= mem_rd_d;
         mem_wr_q    <= mem_wr_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign state     = state_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed and randomized check of pipeline_hazard_ctrl against a queue model
module tb_pipeline_hazard_ctrl;

   localparam int RA_W  = 5;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             id_valid = 1'b0;
   logic [RA_W-1:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic             id_rs1_used = 1'b0, id_rs2_used = 1'b0, id_regwrite = 1'b0;
   logic             pcsrc_mem = 1'b0;
   logic             en_pc, en_ifid, bubble_idex, flush_ifid, flush_exmem;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   pipeline_hazard_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
      .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
      .id_regwrite(id_regwrite), .pcsrc_mem(pcsrc_mem),
      .en_pc(en_pc), .en_ifid(en_ifid), .bubble_idex(bubble_idex),
      .flush_ifid(flush_ifid), .flush_exmem(flush_exmem),
      .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Model: destinations of the two older in-flight instructions (0 = no write).
   int inflight[$];
   int m_state, m_stall, m_flush;
   bit last_hz, last_pc;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit reads_pending(bit used, int r);
      if (!used || r == 0) return 1'b0;
      foreach (inflight[i]) if (inflight[i] == r) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit model_hazard();
      if (!id_valid || m_state == 2) return 1'b0;
      return reads_pending(id_rs1_used, int'(id_rs1)) || reads_pending(id_rs2_used, int'(id_rs2));
   endfunction

   task automatic model_clear();
      inflight = '{0, 0};
      m_state  = 0;
      m_stall  = 0;
      m_flush  = 0;
      last_hz  = 1'b0;
      last_pc  = 1'b0;
   endtask

   task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                         input int rd, input bit rw, input bit pc);
      id_valid    = v;
      id_rs1      = rs1[RA_W-1:0];
      id_rs1_used = u1;
      id_rs2      = rs2[RA_W-1:0];
      id_rs2_used = u2;
      id_rd       = rd[RA_W-1:0];
      id_regwrite = rw;
      pcsrc_mem   = pc;
      #1;
   endtask

   // Check one cycle against the model, then advance both across a rising edge.
   task automatic step();
      bit hz;
      logic [4:0] exp_ctl;
      int entering;
      hz = model_hazard();
      if (pcsrc_mem)  exp_ctl = 5'b11111;
      else if (hz)    exp_ctl = 5'b00100;
      else            exp_ctl = 5'b11000;
      chk("ctl", 64'({en_pc, en_ifid, bubble_idex, flush_ifid, flush_exmem}), 64'(exp_ctl));
      chk("state", 64'(state), 64'(m_state));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
      entering = (hz || !id_valid || m_state == 2 || !id_regwrite) ? 0 : int'(id_rd);
      @(posedge clk);
      inflight.push_front(entering);
      void'(inflight.pop_back());
      if (pcsrc_mem) inflight = '{0, 0};
      m_state = pcsrc_mem ? 2 : (hz ? 1 : 0);
      if (hz && !pcsrc_mem && m_stall < CMAX) m_stall++;
      if (pcsrc_mem && m_flush < CMAX) m_flush++;
      last_hz = hz;
      last_pc = pcsrc_mem;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      chk("rst_ctl", 64'({en_pc, en_ifid, bubble_idex, flush_ifid, flush_exmem}), 64'(5'b00111));
      chk("rst_state", 64'(state), 64'(0));
      chk("rst_cnts", 64'({stall_cnt, flush_cnt}), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_clear();
   endtask

   initial begin
      model_clear();
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;

      // 1: back-to-back RAW on rs1 stalls twice
      do_reset();
      set_id(1, 1, 1, 2, 1, 5, 1, 0); step();
      set_id(1, 5, 1, 0, 0, 6, 1, 0);
      chk("t1_stall_a", 64'({en_pc, bubble_idex}), 64'(2'b01)); step();
      chk("t1_state_a", 64'(state), 64'(1)); step();
      chk("t1_state_b", 64'(state), 64'(1));
      chk("t1_go", 64'(en_pc), 64'(1)); step();
      chk("t1_state_c", 64'(state), 64'(0));
      chk("t1_cnt", 64'(stall_cnt), 64'(2));

      // 2: one independent instruction in between leaves a single stall
      do_reset();
      set_id(1, 0, 0, 0, 0, 7, 1, 0); step();
      set_id(1, 1, 1, 2, 1, 8, 1, 0); step();
      set_id(1, 3, 1, 7, 1, 9, 1, 0);
      chk("t2_stall", 64'(en_pc), 64'(0)); step();
      chk("t2_go", 64'(en_pc), 64'(1)); step();
      chk("t2_cnt", 64'(stall_cnt), 64'(1));

      // 3: x0 and non-writing producers never stall
      do_reset();
      set_id(1, 0, 0, 0, 0, 0, 1, 0); step();
      set_id(1, 0, 1, 0, 1, 4, 0, 0);
      chk("t3_x0", 64'(en_pc), 64'(1)); step();
      set_id(1, 0, 0, 0, 0, 9, 0, 0); step();
      set_id(1, 9, 1, 9, 1, 3, 1, 0);
      chk("t3_norw", 64'(en_pc), 64'(1)); step();
      chk("t3_cnt", 64'(stall_cnt), 64'(0));

      // 4: redirect wins over a hazard and clears the scoreboard
      do_reset();
      set_id(1, 0, 0, 0, 0, 5, 1, 0); step();
      set_id(1, 5, 1, 0, 0, 6, 1, 1);
      chk("t4_ctl", 64'({en_pc, en_ifid, bubble_idex, flush_ifid, flush_exmem}), 64'(5'b11111)); step();
      chk("t4_state", 64'(state), 64'(2));
      chk("t4_cnts", 64'({stall_cnt, flush_cnt}), 64'({4'd0, 4'd1}));
      set_id(1, 5, 1, 0, 0, 6, 1, 0);
      chk("t4_flush_ign", 64'(en_pc), 64'(1)); step();
      chk("t4_sb_clear", 64'(en_pc), 64'(1)); step();

      // 5: back-to-back redirects
      do_reset();
      set_id(1, 0, 0, 0, 0, 2, 1, 1); step();
      chk("t5_s1", 64'(state), 64'(2)); step();
      chk("t5_s2", 64'(state), 64'(2));
      set_id(1, 0, 0, 0, 0, 2, 1, 0); step();
      chk("t5_s3", 64'(state), 64'(0));
      chk("t5_cnt", 64'(flush_cnt), 64'(2));

      // 6: asynchronous reset during a stall
      do_reset();
      set_id(1, 0, 0, 0, 0, 5, 1, 0); step();
      set_id(1, 5, 1, 0, 0, 6, 1, 0); step();
      chk("t6_pre", 64'({state, stall_cnt}), 64'({2'd1, 4'd1}));
      rst = 1'b0;
      #1;
      chk("t6_async", 64'({state, stall_cnt}), 64'(0));
      model_clear();
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("t6_nostall", 64'(en_pc), 64'(1)); step();

      // 7: stall counter saturates
      do_reset();
      for (int k = 0; k < 9; k++) begin
         set_id(1, 0, 0, 0, 0, 5, 1, 0); step();
         set_id(1, 0, 0, 5, 1, 6, 0, 0); step(); step(); step();
      end
      chk("t7_sat", 64'(stall_cnt), 64'(CMAX));

      // random traffic; a stalled instruction stays in ID
      do_reset();
      for (int n = 0; n < 400; n++) begin
         if (!(last_hz && !last_pc)) begin
            set_id($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
         end else begin
            pcsrc_mem = ($urandom_range(0, 7) == 0);
            #1;
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
